// File: rtl/mbssoc_mem_ctrl.sv
// Purpose : core-side load/store controller for the SoC word RAM; sub-word stores
//           are read-modify-write, loads are sign/zero-extended, bad requests rejected.
// Latency : done in cycle 1 (error), 2 (word store), 3 (load), 4 (sub-word store) after accept.
// Backpr. : core_ready=1 only in IDLE; core inputs are ignored while an access is in flight.
// Ports   : clk/rst_n           - clock, async active-low reset
//           core_req/core_we/core_size/core_unsigned/core_addr/core_wdata - request in
//           core_ready/core_done/core_err/core_rdata                      - handshake/result
//           ram_we/ram_re/ram_addr/ram_data - word RAM port on a shared bidirectional bus
module mbssoc_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [1:0]            core_size,
  input  logic                  core_unsigned,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ready,
  output logic                  core_done,
  output logic                  core_err,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_WR,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [15:0]             wdata_q, wdata_d;   // only the sub-word lane data is needed after accept
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wr_word_q, wr_word_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    req_err;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;

  assign req_err = (core_size == SZ_ILL)
                 | ((core_size == SZ_HALF) & core_addr[0])
                 | ((core_size == SZ_WORD) & (|core_addr[1:0]));

  // Little-endian lane select from the word currently on the bus (valid in RD1).
  assign rd_byte = ram_data[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = ram_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = ram_data;
    case (size_q)
      SZ_BYTE: load_ext = {{(DATA_WIDTH-8){~uns_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_ext = {{(DATA_WIDTH-16){~uns_q & rd_half[15]}}, rd_half};
      default: load_ext = ram_data;
    endcase
  end

  // Read word with only the addressed lane replaced by the store data.
  always_comb begin
    merged = ram_data;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (core_req) begin
          addr_d    = core_addr;
          we_d      = core_we;
          size_d    = core_size;
          uns_d     = core_unsigned;
          wdata_d   = core_wdata[15:0];
          err_d     = req_err;
          // Word stores skip the read and write the core data unchanged.
          wr_word_d = core_wdata;
          if (req_err) begin
            state_d = S_RESP;
          end else if (!core_we || (core_size != SZ_WORD)) begin
            state_d = S_RD0;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        if (we_q) begin
          wr_word_d = merged;
          state_d   = S_WR;
        end else begin
          rdata_d   = load_ext;
          state_d   = S_RESP;
        end
      end
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
    end
  end

  // RAM strobes and bus enable come from the state register alone, so they are
  // glitch-free and can never overlap.
  assign ram_re     = (state_q == S_RD0) || (state_q == S_RD1);
  assign ram_we     = (state_q == S_WR);
  assign ram_addr   = (ram_re || ram_we) ? addr_q : '0;
  assign ram_data   = ram_we ? wr_word_q : 'z;

  assign core_ready = (state_q == S_IDLE);
  assign core_done  = (state_q == S_RESP);
  assign core_err   = core_done & err_q;
  assign core_rdata = rdata_q;

endmodule

// File: tb/tb_mbssoc_mem_ctrl.sv
// Bench for mbssoc_mem_ctrl: a small word RAM on the shared bus, a per-cycle
// reference model of the controller's externally visible behaviour, and
// directed requests with hand-computed results.
`timescale 1ns/1ps
module tb_mbssoc_mem_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [1:0]    core_size = 2'b00;
  logic          core_unsigned = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_ready, core_done, core_err;
  logic [DW-1:0] core_rdata;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  mbssoc_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_size(core_size),
    .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ready(core_ready), .core_done(core_done), .core_err(core_err),
    .core_rdata(core_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: registers the word address while reading, drives the bus while ram_re.
  logic [DW-1:0] ram_mem [0:63];
  logic [5:0]    ra_q = '0;
  always @(posedge clk) begin
    if (ram_re) ra_q <= ram_addr[7:2];
    if (ram_we) ram_mem[ram_addr[7:2]] <= ram_data;
  end
  assign ram_data = ram_re ? ram_mem[ra_q] : 'z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_val(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin mask = 32'hFF;   sh = 8 * a[1:0]; end
    else            begin mask = 32'hFFFF; sh = 16 * a[1];  end
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // Reference model: what each request must do, in cycles relative to its accept.
  logic [31:0] mem_m [0:63];
  int          m_done_at = -100, m_re0 = -100, m_we_at = -100, m_widx = 0;
  logic        m_err = 1'b0, m_pend = 1'b0;
  logic [31:0] m_rdata = '0, m_res = '0, m_wword = '0, m_addr = '0;

  always @(negedge clk) begin : cmp
    logic [31:0] a, rd;
    int          idx;
    logic        e;
    if (!rst_n) begin
      m_done_at = -100; m_re0 = -100; m_we_at = -100; m_pend = 1'b0; m_rdata = '0;
      chk("rst_ready",  32'(core_ready), 32'd1);
      chk("rst_done",   32'(core_done),  32'd0);
      chk("rst_err",    32'(core_err),   32'd0);
      chk("rst_rdata",  core_rdata,      32'd0);
      chk("rst_ram_we", 32'(ram_we),     32'd0);
      chk("rst_ram_re", 32'(ram_re),     32'd0);
      chk("rst_addr",   ram_addr,        32'd0);
    end else begin
      if (m_pend && cyc == m_done_at) begin
        m_rdata = m_res;
        m_pend  = 1'b0;
      end
      chk("ready",  32'(core_ready), 32'(cyc > m_done_at));
      chk("done",   32'(core_done),  32'(cyc == m_done_at));
      if (cyc == m_done_at) chk("err", 32'(core_err), 32'(m_err));
      chk("rdata",  core_rdata, m_rdata);
      chk("ram_re", 32'(ram_re), 32'((cyc == m_re0) || (cyc == m_re0 + 1)));
      chk("ram_we", 32'(ram_we), 32'(cyc == m_we_at));
      chk("we_and_re", 32'(ram_we & ram_re), 32'd0);
      if (cyc == m_re0 || cyc == m_re0 + 1 || cyc == m_we_at) chk("ram_addr", ram_addr, m_addr);
      if (cyc == m_we_at) begin
        chk("ram_wdata", ram_data, m_wword);
        mem_m[m_widx] = m_wword;
      end
      if (core_req && core_ready) begin
        a = core_addr; idx = int'(a[7:2]); rd = mem_m[idx];
        e = (core_size == 2'd3) || (core_size == 2'd1 && a[0]) || (core_size == 2'd2 && a[1:0] != 2'd0);
        m_err = e; m_addr = a;
        if (e) begin
          m_done_at = cyc + 1;
        end else if (!core_we) begin
          m_done_at = cyc + 3; m_re0 = cyc + 1; m_pend = 1'b1;
          m_res = load_val(rd, a, core_size, core_unsigned);
        end else if (core_size == 2'd2) begin
          m_done_at = cyc + 2; m_we_at = cyc + 1; m_wword = core_wdata; m_widx = idx;
        end else begin
          m_done_at = cyc + 4; m_re0 = cyc + 1; m_we_at = cyc + 3; m_widx = idx;
          m_wword = merge_val(rd, a, core_size, core_wdata);
        end
      end
    end
  end

  // Present a request and wait for it to be accepted; with hold=1 core_req stays
  // high and the other inputs carry junk while the access is in flight.
  task automatic present(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic hold);
    logic got = 1'b0;
    core_req = 1'b1; core_we = we; core_size = sz; core_unsigned = u;
    core_addr = a; core_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (core_ready) begin got = 1'b1; acc_cyc = cyc; end
    end
    chk("accepted", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (hold) begin
      core_we = ~we; core_size = 2'b11; core_unsigned = ~u;
      core_addr = 32'hFFFF_FFFF; core_wdata = 32'hA5A5_A5A5;
    end else begin
      core_req = 1'b0;
    end
  endtask

  task automatic finish_op(input string nm, input int lat, input logic err, input logic [31:0] rdata);
    logic seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (core_done) begin
        seen = 1'b1;
        chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'(lat));
        chk({nm, "_err"},     32'(core_err),      32'(err));
        chk({nm, "_rdata"},   core_rdata,         rdata);
      end
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic op(input string nm, input logic we, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] d, input logic hold,
                    input int lat, input logic err, input logic [31:0] rdata);
    present(we, sz, u, a, d, hold);
    finish_op(nm, lat, err, rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'h0101_0101 * i;
      mem_m[i]   = 32'h0101_0101 * i;
    end
    ram_mem[4] = 32'hDEAD_BEEF;
    mem_m[4]   = 32'hDEAD_BEEF;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    //  name       we sz  u  addr    wdata         hold lat err rdata
    op("lw10",    0, 2, 0, 32'h10, 32'h0,         0, 3, 0, 32'hDEAD_BEEF);
    op("lb13",    0, 0, 0, 32'h13, 32'h0,         0, 3, 0, 32'hFFFF_FFDE);
    op("lbu13",   0, 0, 1, 32'h13, 32'h0,         0, 3, 0, 32'h0000_00DE);
    op("lh12",    0, 1, 0, 32'h12, 32'h0,         0, 3, 0, 32'hFFFF_DEAD);
    op("lhu10",   0, 1, 1, 32'h10, 32'h0,         0, 3, 0, 32'h0000_BEEF);
    op("sb11",    1, 0, 0, 32'h11, 32'h55,        0, 4, 0, 32'h0000_BEEF);
    op("lw10b",   0, 2, 0, 32'h10, 32'h0,         0, 3, 0, 32'hDEAD_55EF);
    op("sw10",    1, 2, 0, 32'h10, 32'h1234_5678, 0, 2, 0, 32'hDEAD_55EF);
    op("sh12",    1, 1, 0, 32'h12, 32'hFFFF_ABCD, 0, 4, 0, 32'hDEAD_55EF);
    op("lw10c",   0, 2, 0, 32'h10, 32'h0,         0, 3, 0, 32'hABCD_5678);
    op("lb10",    0, 0, 0, 32'h10, 32'h0,         0, 3, 0, 32'h0000_0078);
    op("lw12err", 0, 2, 0, 32'h12, 32'h0,         0, 1, 1, 32'h0000_0078);
    op("sh11err", 1, 1, 0, 32'h11, 32'h7777,      0, 1, 1, 32'h0000_0078);
    op("sz3err",  1, 3, 0, 32'h10, 32'h7777,      0, 1, 1, 32'h0000_0078);
    chk("ram_after_errs", ram_mem[4], 32'hABCD_5678);

    // Abort a byte store during its read phase.
    present(1, 0, 0, 32'h10, 32'h99, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ram_word", ram_mem[4], 32'hABCD_5678);
    op("lw_after_rst", 0, 2, 0, 32'h10, 32'h0,    0, 3, 0, 32'hABCD_5678);

    // Back-to-back with core_req held high throughout.
    op("h_sb13",  1, 0, 0, 32'h13, 32'h11,        1, 4, 0, 32'hABCD_5678);
    op("h_lhu12", 0, 1, 1, 32'h12, 32'h0,         1, 3, 0, 32'h0000_11CD);
    op("h_err",   0, 3, 0, 32'h0,  32'h0,         1, 1, 1, 32'h0000_11CD);
    op("h_lw10",  0, 2, 0, 32'h10, 32'h0,         1, 3, 0, 32'h11CD_5678);
    core_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_ram_word", ram_mem[4], 32'h11CD_5678);
    chk("final_model_word", ram_mem[4], mem_m[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
